systolic_tile_sequencer: RTL

//  Sequences multi-tile runs of systolic_array_top_AXI_seq. Sits between the read-side FIFO and the array input, and between
//  the array output and the write-side FIFO. Per tile it forwards WGT beats then ACT beats with phase tlast, meters output

---
 rtl/systolic_tile_sequencer_if.sv | 11 +
 rtl/systolic_tile_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/systolic_tile_sequencer_if.sv
// systolic_tile_sequencer_if: valid/ready stream bundle; the slave side carries no tlast.
interface systolic_tile_sequencer_if #(
    parameter int W = 128
);
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [W-1:0] tdata;
    modport master (output tvalid, tdata, tlast, input tready);
    modport slave  (input tvalid, tdata, output tready);
endinterface

// File: rtl/systolic_tile_sequencer.sv
// systolic_tile_sequencer: per-tile WGT/ACT input phasing, output metering and run control for the systolic array.
module systolic_tile_sequencer #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CNT_WIDTH-1:0]          cfg_num_tiles,
    input  logic [CNT_WIDTH-1:0]          cfg_wgt_beats,
    input  logic [CNT_WIDTH-1:0]          cfg_act_beats,
    input  logic [CNT_WIDTH-1:0]          cfg_out_beats,
    output logic                          busy,
    output logic                          done,
    output logic                          err_ovf,
    input  logic                          out_prog_full,
    systolic_tile_sequencer_if.slave      s,
    systolic_tile_sequencer_if.master     sa,
    systolic_tile_sequencer_if.slave      sa_out,
    systolic_tile_sequencer_if.master     m
);
    typedef enum logic [2:0] {IDLE, WGT, ACT, DRAIN, FIN} state_t;
    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] num_tiles, wgt_beats, act_beats, out_beats;
    logic [CNT_WIDTH-1:0] in_cnt, out_cnt, tile_cnt, tile_nxt;
    logic                 tile_done;
    logic                 in_en, out_en, in_hs, out_hs, in_last, out_last, drain_ok;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cfg_num_tiles == '0 ? FIN : WGT;
            WGT:     if (wgt_beats == '0 || (in_hs && in_last)) state_nxt = ACT;
            ACT:     if (act_beats == '0 || (in_hs && in_last)) state_nxt = DRAIN;
            DRAIN:   if (drain_ok) state_nxt = tile_nxt == num_tiles ? FIN : WGT;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_en        = (state == WGT && wgt_beats != '0) || (state == ACT && act_beats != '0 && !out_prog_full);
        // Once the tile's results are complete, further array output is refused rather than leaked into the next tile.
        out_en       = (state == ACT || state == DRAIN) && !tile_done && out_beats != '0;
        in_last      = in_cnt == (state == WGT ? wgt_beats : act_beats) - 1'b1;
        out_last     = out_cnt == out_beats - 1'b1;
        in_hs        = in_en && s.tvalid && sa.tready;
        out_hs       = out_en && sa_out.tvalid && m.tready;
        drain_ok     = tile_done || out_beats == '0 || (out_hs && out_last);
        tile_nxt     = tile_cnt + 1'b1;
        sa.tvalid    = in_en && s.tvalid;
        s.tready     = in_en && sa.tready;
        sa.tlast     = in_en && in_last;
        sa.tdata     = IN_WIDTH'(s.tdata);
        m.tvalid     = out_en && sa_out.tvalid;
        sa_out.tready = out_en && m.tready;
        m.tlast      = out_en && out_last;
        m.tdata      = OUT_WIDTH'(sa_out.tdata);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_tiles <= '0;
            wgt_beats <= '0;
            act_beats <= '0;
            out_beats <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            tile_cnt  <= '0;
            tile_done <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            done <= state == FIN;
            if (state == FIN) busy <= 1'b0;
            if (state == IDLE && start) begin
                num_tiles <= cfg_num_tiles;
                wgt_beats <= cfg_wgt_beats;
                act_beats <= cfg_act_beats;
                out_beats <= cfg_out_beats;
                in_cnt    <= '0;
                out_cnt   <= '0;
                tile_cnt  <= '0;
                tile_done <= 1'b0;
                busy      <= 1'b1;
                err_ovf   <= 1'b0;
            end
            if (in_hs) in_cnt <= in_last ? '0 : in_cnt + 1'b1;
            if (out_hs) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
            if (state == DRAIN && drain_ok) begin
                tile_done <= 1'b0;
                tile_cnt  <= tile_nxt;
            end else if (out_hs && out_last) begin
                tile_done <= 1'b1;
            end
            if (sa_out.tvalid && (state == WGT || state == FIN || tile_done)) err_ovf <= 1'b1;
        end
    end
endmodule
